// File: rtl/i2c_master_byte_seq.sv
// Byte-level I2C sequencer: expands one host request into START/WRITE/READ/ACK/STOP bit commands.
// Optional per-bit-command watchdog (to_o) when I2C_BYTE_SEQ_TIMEOUT_EN is defined.
module i2c_master_byte_seq #(
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ena_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic       ack_i,
    input  logic [7:0] din_i,
    output logic       cmd_ack_o,
    output logic       ack_o,
    output logic [7:0] dout_o,
    output logic       i2c_busy_o,
    output logic       i2c_al_o,
    output logic [3:0] bit_cmd_o,
    output logic       bit_dat_o,
    input  logic       bit_dat_i,
    input  logic       bit_ack_i,
    input  logic       bit_busy_i,
    input  logic       bit_al_i
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    ,
    output logic       to_o
`endif
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] cmd_q, cmd_d;
    logic       dat_q, dat_d;
    logic       cmd_ack_q, cmd_ack_d;
    logic       ack_q, ack_d;
    logic [7:0] dout_q, dout_d;
    logic       go;

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic                 to_q, to_d;
`endif

    // ~cmd_ack_q keeps a still-held request from re-firing in the completion cycle
    assign go = (read_i | write_i | stop_i) & ~cmd_ack_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            cmd_q     <= CMD_NOP;
            dat_q     <= 1'b0;
            cmd_ack_q <= 1'b0;
            ack_q     <= 1'b0;
            dout_q    <= '0;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
            tcnt_q    <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            dat_q     <= dat_d;
            cmd_ack_q <= cmd_ack_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            to_q      <= to_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        dat_d     = dat_q;
        cmd_ack_d = 1'b0;
        ack_d     = ack_q;
        dout_d    = dout_q;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        // idle (NOP) or an acknowledged command restarts the watchdog
        tcnt_d = (bit_ack_i || cmd_q == CMD_NOP) ? '0 : tcnt_q + 1'b1;
        to_d   = 1'b0;
`endif
        if (bit_al_i || !ena_i) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NOP;
            dat_d   = 1'b0;
        end
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        else if (cmd_q != CMD_NOP && !bit_ack_i && tcnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_NOP;
            dat_d   = 1'b0;
            to_d    = 1'b1;
        end
`endif
        else begin
            case (state_q)
                ST_IDLE: if (go) begin
                    sr_d  = din_i;
                    cnt_d = 3'd7;
                    dat_d = 1'b0;
                    if (start_i) begin
                        state_d = ST_START; cmd_d = CMD_START;
                    end else if (read_i) begin
                        state_d = ST_READ;  cmd_d = CMD_READ;
                    end else if (write_i) begin
                        state_d = ST_WRITE; cmd_d = CMD_WRITE; dat_d = din_i[7];
                    end else begin
                        state_d = ST_STOP;  cmd_d = CMD_STOP;
                    end
                end
                ST_START: if (bit_ack_i) begin
                    if (read_i) begin
                        state_d = ST_READ;  cmd_d = CMD_READ;  dat_d = 1'b0;
                    end else begin
                        state_d = ST_WRITE; cmd_d = CMD_WRITE; dat_d = sr_q[7];
                    end
                end
                ST_WRITE, ST_READ: if (bit_ack_i) begin
                    sr_d = {sr_q[6:0], bit_dat_i};
                    if (cnt_q == 3'd0) begin
                        // write: sample slave ACK with a READ; read: drive master ACK with a WRITE
                        state_d = ST_ACK;
                        cmd_d   = (state_q == ST_WRITE) ? CMD_READ : CMD_WRITE;
                        dat_d   = (state_q == ST_WRITE) ? 1'b0 : ack_i;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                        dat_d = (state_q == ST_WRITE) ? sr_q[6] : 1'b0;
                    end
                end
                ST_ACK: if (bit_ack_i) begin
                    ack_d  = bit_dat_i;
                    dout_d = sr_q;
                    dat_d  = 1'b0;
                    if (stop_i) begin
                        state_d = ST_STOP; cmd_d = CMD_STOP;
                    end else begin
                        state_d = ST_IDLE; cmd_d = CMD_NOP; cmd_ack_d = 1'b1;
                    end
                end
                ST_STOP: if (bit_ack_i) begin
                    state_d   = ST_IDLE;
                    cmd_d     = CMD_NOP;
                    cmd_ack_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NOP;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ack_o  = cmd_ack_q;
        ack_o      = ack_q;
        dout_o     = dout_q;
        bit_cmd_o  = cmd_q;
        bit_dat_o  = dat_q;
        i2c_busy_o = bit_busy_i;
        i2c_al_o   = bit_al_i;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        to_o       = to_q;
`endif
    end

endmodule
